// File: rtl/pos_ctrl_pkg.sv
// Shared types and constants for the cell position RAM access controller.
package pos_ctrl_pkg;

  // Width of the id carried in a read tag; bounds the addressable RAM depth.
  localparam int TAG_ID_W = 8;

  // RAM word that holds the particle count of the cell.
  localparam logic [TAG_ID_W-1:0] COUNT_ADDR = '0;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN,
    DONE
  } ctrl_state_t;

  // Travels alongside each read until its data returns from the RAM.
  typedef struct packed {
    logic                valid;
    logic                is_count;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/pos_rd_tag_pipe.sv
// Read-tag delay line matching the RAM read latency, with an empty flag.
module pos_rd_tag_pipe
  import pos_ctrl_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    empty
);

  rd_tag_t stage [RD_LATENCY];

  // Shift tags one stage per cycle; reset discards reads still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[RD_LATENCY-1];

  // Pipe is empty when no stage holds an outstanding read.
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (stage[i].valid) empty = 1'b0;
    end
  end

endmodule

// File: rtl/pos_cell_access_ctrl.sv
// Single-port cell position RAM sequencer: streams a cell's particles to the
// force side while arbitrating motion-update writes with bounded priority.
module pos_cell_access_ctrl
  import pos_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_id,
  output logic                  out_last,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  ctrl_state_t           state, state_nx;
  logic [ADDR_WIDTH-1:0] count, next_addr, rd_addr, cnt_clamped;
  logic [SW-1:0]         starve_cnt;
  logic                  rd_pending, wr_grant, wr_in_range, rd_issue;
  logic                  cnt_ret, data_ret, tag_empty;
  rd_tag_t               tag_in, tag_ret;

  pos_rd_tag_pipe #(.RD_LATENCY(RD_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_ret),
    .empty   (tag_empty)
  );

  assign rd_pending  = (state == RD_CNT) || (state == STREAM);
  // Gated by rst_n so the port is quiet while reset is held.
  assign wr_ready    = rst_n & ~(rd_pending & (starve_cnt == SW'(STARVE_LIMIT)));
  assign wr_grant    = wr_valid & wr_ready;
  assign wr_in_range = 32'(wr_addr) < 32'(PARTICLE_NUM);
  // A granted write owns the port even when it is dropped as out of range.
  assign rd_issue    = rd_pending & ~wr_grant;
  assign rd_addr     = (state == RD_CNT) ? ADDR_WIDTH'(COUNT_ADDR) : next_addr;
  assign cnt_ret     = tag_ret.valid & tag_ret.is_count;
  assign data_ret    = tag_ret.valid & ~tag_ret.is_count;
  assign cnt_clamped = (32'(mem_q[ADDR_WIDTH-1:0]) > 32'(PARTICLE_NUM - 1))
                       ? ADDR_WIDTH'(PARTICLE_NUM - 1) : mem_q[ADDR_WIDTH-1:0];
  assign rd_busy     = (state != IDLE);
  assign rd_done     = (state == DONE);

  // Next-state, RAM port mux and read-tag generation.
  always_comb begin
    state_nx    = state;
    mem_address = '0;
    mem_data    = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    tag_in      = '0;
    case (state)
      IDLE:     if (rd_start) state_nx = RD_CNT;
      RD_CNT:   if (rd_issue) state_nx = WAIT_CNT;
      WAIT_CNT: if (cnt_ret) state_nx = (cnt_clamped == '0) ? DONE : STREAM;
      STREAM:   if (rd_issue && (next_addr == count)) state_nx = DRAIN;
      DRAIN:    if (tag_empty) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (wr_grant && wr_in_range) begin
      mem_wren    = 1'b1;
      mem_address = wr_addr;
      mem_data    = wr_data;
    end else if (rd_issue) begin
      mem_rden    = 1'b1;
      mem_address = rd_addr;
    end
    if (rd_issue) begin
      tag_in.valid    = 1'b1;
      tag_in.is_count = (state == RD_CNT);
      tag_in.id       = TAG_ID_W'(rd_addr);
    end
  end

  // State, latched count, read address and write-starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      next_addr  <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == WAIT_CNT && cnt_ret) begin
        count     <= cnt_clamped;
        next_addr <= ADDR_WIDTH'(1);
      end else if (state == STREAM && rd_issue) begin
        next_addr <= next_addr + ADDR_WIDTH'(1);
      end
      if (rd_pending && wr_grant) starve_cnt <= starve_cnt + SW'(1);
      else                        starve_cnt <= '0;
    end
  end

  // Register returning particle data; data/id hold when no new word arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else if (data_ret) begin
      out_valid <= 1'b1;
      out_data  <= mem_q;
      out_id    <= ADDR_WIDTH'(tag_ret.id);
      out_last  <= (ADDR_WIDTH'(tag_ret.id) == count);
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// Directed bench for pos_cell_access_ctrl with a 2-cycle-latency RAM model.
module tb_pos_cell_access_ctrl;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int NL = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_start = 1'b0;
  logic          rd_busy, rd_done, out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_id;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_q;
  logic          mem_rden, mem_wren;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pos_cell_access_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN),
    .RD_LATENCY(2), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .rd_busy(rd_busy),
    .rd_done(rd_done), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_last(out_last), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // RAM model: data appears two cycles after a sampled read enable.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] q_p1 = '0, q_p2 = '0;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    if (mem_rden) q_p1 <= ram[mem_address];
    q_p2 <= q_p1;
  end
  assign mem_q = q_p2;

  function automatic logic [DW-1:0] word(input int k);
    return {32'hA000_0000 | 32'(k), 32'hB000_0000 | 32'(k), 32'hC000_0000 | 32'(k)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [AW-1:0] lg_addr [NL];
  logic [AW-1:0] lg_id   [NL];
  logic [DW-1:0] lg_data [NL];
  logic          lg_rden [NL];
  logic          lg_wren [NL];
  logic          lg_wrdy [NL];
  logic          lg_ov   [NL];
  logic          lg_last [NL];
  logic          lg_done [NL];
  logic          lg_busy [NL];

  // Cycle 0 carries rd_start; writes are requested over [wr_from, wr_to].
  task automatic run(input int ncyc, input int wr_from, input int wr_to,
                     input logic [AW-1:0] waddr, input int extra_start);
    for (int c = 0; c < ncyc; c++) begin
      rd_start = (c == 0) || (c == extra_start);
      wr_valid = (c >= wr_from) && (c <= wr_to);
      wr_addr  = waddr;
      wr_data  = {32'hD, 32'hE, 32'(c)};
      @(negedge clk);
      lg_addr[c] = mem_address; lg_rden[c] = mem_rden; lg_wren[c] = mem_wren;
      lg_wrdy[c] = wr_ready;    lg_ov[c]   = out_valid; lg_id[c]  = out_id;
      lg_data[c] = out_data;    lg_last[c] = out_last;  lg_done[c] = rd_done;
      lg_busy[c] = rd_busy;
      @(posedge clk); #1;
    end
    rd_start = 1'b0;
    wr_valid = 1'b0;
  endtask

  function automatic int count_ov(input int ncyc);
    int n = 0;
    for (int c = 0; c < ncyc; c++) if (lg_ov[c]) n++;
    return n;
  endfunction

  function automatic int count_done(input int ncyc);
    int n = 0;
    for (int c = 0; c < ncyc; c++) if (lg_done[c]) n++;
    return n;
  endfunction

  initial begin
    for (int k = 0; k < 256; k++) ram[k] = word(k);
    #2;
    chk("rst_busy", rd_busy, 1'b0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_rden", mem_rden, 1'b0);
    chk("rst_wrdy", wr_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic stream of three, with an ignored second rd_start while busy.
    ram[0] = {64'h0, 32'd3};
    run(14, -1, -1, '0, 5);
    chk("b_rden1", {lg_rden[1], lg_addr[1]}, {1'b1, 8'd0});
    chk("b_rden4", {lg_rden[4], lg_addr[4]}, {1'b1, 8'd1});
    chk("b_rden5", {lg_rden[5], lg_addr[5]}, {1'b1, 8'd2});
    chk("b_rden6", {lg_rden[6], lg_addr[6]}, {1'b1, 8'd3});
    chk("b_out7", {lg_ov[7], lg_id[7], lg_last[7]}, {1'b1, 8'd1, 1'b0});
    chk("b_out8", {lg_ov[8], lg_id[8], lg_last[8]}, {1'b1, 8'd2, 1'b0});
    chk("b_out9", {lg_ov[9], lg_id[9], lg_last[9]}, {1'b1, 8'd3, 1'b1});
    chk("b_data8", lg_data[8], word(2));
    chk("b_done10", lg_done[10], 1'b1);
    chk("b_ndone", count_done(14), 1);
    chk("b_busy1", lg_busy[1], 1'b1);
    chk("b_busy11", lg_busy[11], 1'b0);
    chk("b_nov", count_ov(14), 3);
    chk("b_hold10", {lg_ov[10], lg_last[10], lg_id[10]}, {1'b0, 1'b0, 8'd3});

    // Empty cell.
    ram[0] = '0;
    run(8, -1, -1, '0, -1);
    chk("e_done3", lg_done[3], 1'b0);
    chk("e_done4", lg_done[4], 1'b1);
    chk("e_nov", count_ov(8), 0);

    // One write interleaved at cycle 5.
    ram[0] = {64'h0, 32'd3};
    run(14, 5, 5, 8'd9, -1);
    chk("i_wr5", {lg_wren[5], lg_rden[5], lg_addr[5]}, {1'b1, 1'b0, 8'd9});
    chk("i_rd6", {lg_rden[6], lg_addr[6]}, {1'b1, 8'd2});
    chk("i_rd7", {lg_rden[7], lg_addr[7]}, {1'b1, 8'd3});
    chk("i_out7", {lg_ov[7], lg_id[7]}, {1'b1, 8'd1});
    chk("i_gap8", lg_ov[8], 1'b0);
    chk("i_out9", {lg_ov[9], lg_id[9]}, {1'b1, 8'd2});
    chk("i_out10", {lg_ov[10], lg_id[10], lg_last[10]}, {1'b1, 8'd3, 1'b1});
    chk("i_done11", {lg_done[10], lg_done[11]}, {1'b0, 1'b1});
    chk("i_ram9", ram[9], {32'hD, 32'hE, 32'd5});
    ram[9] = word(9);

    // Continuous writes from cycle 4: every fifth slot goes to the read.
    run(26, 4, 25, 8'd20, -1);
    chk("s_wr7", {lg_wren[7], lg_wrdy[7]}, {1'b1, 1'b1});
    chk("s_rd8", {lg_wrdy[8], lg_rden[8], lg_wren[8], lg_addr[8]}, {1'b0, 1'b1, 1'b0, 8'd1});
    chk("s_wr12", lg_wrdy[12], 1'b1);
    chk("s_rd13", {lg_wrdy[13], lg_rden[13], lg_addr[13]}, {1'b0, 1'b1, 8'd2});
    chk("s_rd18", {lg_rden[18], lg_addr[18]}, {1'b1, 8'd3});
    chk("s_wr19", {lg_wrdy[19], lg_wren[19]}, {1'b1, 1'b1});
    chk("s_out", {lg_ov[11], lg_id[11], lg_ov[16], lg_id[16], lg_ov[21], lg_id[21]},
        {1'b1, 8'd1, 1'b1, 8'd2, 1'b1, 8'd3});
    chk("s_done22", lg_done[22], 1'b1);
    chk("s_nov", count_ov(26), 3);
    ram[20] = word(20);

    // Out-of-range write accepted but dropped; in-range write goes through.
    wr_valid = 1'b1; wr_addr = 8'd230; wr_data = '1;
    @(negedge clk);
    chk("d_ack230", wr_ready, 1'b1);
    chk("d_wren230", mem_wren, 1'b0);
    wr_addr = 8'd219; wr_data = word(219);
    #1;
    chk("d_wren219", {mem_wren, mem_address}, {1'b1, 8'd219});
    @(posedge clk); #1;
    wr_valid = 1'b0;

    // Count word 250 clamps to 219.
    ram[0] = {64'hFFFF, 32'd250};
    run(230, -1, -1, '0, -1);
    chk("c_last", {lg_ov[225], lg_id[225], lg_last[225]}, {1'b1, 8'd219, 1'b1});
    chk("c_data", lg_data[225], word(219));
    chk("c_done", {lg_done[225], lg_done[226]}, {1'b0, 1'b1});
    chk("c_nov", count_ov(230), 219);

    // Reset asserted in the middle of a stream of five.
    ram[0] = {64'h0, 32'd5};
    run(7, -1, -1, '0, -1);
    @(negedge clk);
    chk("r_pre", {out_valid, mem_rden, mem_address}, {1'b1, 1'b1, 8'd4});
    #1 rst_n = 1'b0; wr_valid = 1'b1; wr_addr = 8'd7;
    #1;
    chk("r_out", {out_valid, out_id, out_last, rd_busy, rd_done}, 12'h0);
    chk("r_mem", {mem_rden, mem_wren, mem_address, wr_ready}, 11'h0);
    chk("r_data", out_data, '0);
    wr_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    ram[0] = {64'h0, 32'd3};
    run(12, -1, -1, '0, -1);
    chk("r_again7", {lg_ov[7], lg_id[7]}, {1'b1, 8'd1});
    chk("r_again10", lg_done[10], 1'b1);
    chk("r_ndone", count_done(12), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
